// File: rtl/sap_datapath_if.sv
// sap_datapath_if
// Groups every non-clock signal between the SAP datapath and the outside
// world: the control word from the microcode controller, the opcode and
// stage reset returned to it, the program-load port and the status/debug
// outputs.
//   master : controller / host side (drives ctrl, start, prog_*)
//   slave  : datapath side (drives opcode, ctrl_rst, prog_rdata, status)
interface sap_datapath_if;
    logic [12:0] ctrl;        // hlt,pc_inc,pc_en,mar_load,mem_st,mem_en,ir_load,ir_en,a_load,a_en,b_load,adder_sub,adder_en
    logic [3:0]  opcode;      // IR[7:4]
    logic        ctrl_rst;    // controller stage reset
    logic        start;       // begin execution
    logic        prog_we;     // program write strobe
    logic [3:0]  prog_addr;   // program write / readback address
    logic [7:0]  prog_data;   // program write data
    logic [7:0]  prog_rdata;  // RAM[prog_addr]
    logic [7:0]  a_out;       // accumulator
    logic [3:0]  pc_out;      // program counter
    logic [7:0]  bus_out;     // bus value (debug)
    logic        cf;          // carry / no-borrow
    logic        zf;          // zero
    logic        running;     // executing
    logic        halted;      // stopped after hlt or contention
    logic        bus_err;     // sticky bus contention

    modport master (
        output ctrl, start, prog_we, prog_addr, prog_data,
        input  opcode, ctrl_rst, prog_rdata, a_out, pc_out, bus_out,
               cf, zf, running, halted, bus_err
    );

    modport slave (
        input  ctrl, start, prog_we, prog_addr, prog_data,
        output opcode, ctrl_rst, prog_rdata, a_out, pc_out, bus_out,
               cf, zf, running, halted, bus_err
    );
endinterface

// File: rtl/sap_datapath.sv
// sap_datapath
// Register/bus datapath of the 8-bit SAP-style CPU. Executes the 13-bit
// control word from the microcode controller over a shared 8-bit bus
// (PC, MAR, 16x8 RAM, IR, A, B, adder/subtractor), returns the opcode, and
// owns program loading, LOAD/RUN/HALT sequencing and the controller's
// stage reset.
// Ports:
//   clk  : system clock, state updates on the rising edge
//   rst  : asynchronous active-high reset
//   dp   : sap_datapath_if.slave bundle (control word, program port, status)
module sap_datapath (
    input  logic          clk,
    input  logic          rst,
    sap_datapath_if.slave dp
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_pc;
    logic [3:0]  r_mar;
    logic [7:0]  r_ir;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_cf;
    logic        r_zf;
    logic        r_bus_err;
    logic        r_ctrl_rst;
    logic [7:0]  r_ram [0:15];

    // Control word fields
    logic w_hlt, w_pc_inc, w_pc_en, w_mar_load, w_mem_st, w_mem_en;
    logic w_ir_load, w_ir_en, w_a_load, w_a_en, w_b_load, w_adder_sub, w_adder_en;

    assign w_hlt       = dp.ctrl[12];
    assign w_pc_inc    = dp.ctrl[11];
    assign w_pc_en     = dp.ctrl[10];
    assign w_mar_load  = dp.ctrl[9];
    assign w_mem_st    = dp.ctrl[8];
    assign w_mem_en    = dp.ctrl[7];
    assign w_ir_load   = dp.ctrl[6];
    assign w_ir_en     = dp.ctrl[5];
    assign w_a_load    = dp.ctrl[4];
    assign w_a_en      = dp.ctrl[3];
    assign w_b_load    = dp.ctrl[2];
    assign w_adder_sub = dp.ctrl[1];
    assign w_adder_en  = dp.ctrl[0];

    logic [7:0] w_ram_q;
    logic [8:0] w_sum9;
    logic [7:0] w_bus;
    logic [2:0] w_drv_cnt;
    logic       w_run;
    logic       w_contend;
    logic       w_exec;

    assign w_ram_q = r_ram[r_mar];

    // Subtraction as A + ~B + 1: bit 8 of that sum is exactly the no-borrow (A >= B) flag.
    assign w_sum9 = {1'b0, r_a}
                  + {1'b0, (w_adder_sub ? ~r_b : r_b)}
                  + {8'h00, w_adder_sub};

    // Wired-OR bus: under contention the debug output shows all drivers merged.
    assign w_bus = (w_pc_en    ? {4'h0, r_pc}      : 8'h00)
                 | (w_mem_en   ? w_ram_q           : 8'h00)
                 | (w_ir_en    ? {4'h0, r_ir[3:0]} : 8'h00)
                 | (w_a_en     ? r_a               : 8'h00)
                 | (w_adder_en ? w_sum9[7:0]       : 8'h00);

    assign w_drv_cnt = {2'b00, w_pc_en} + {2'b00, w_mem_en} + {2'b00, w_ir_en}
                     + {2'b00, w_a_en}  + {2'b00, w_adder_en};

    assign w_run     = (r_state == ST_RUN);
    assign w_contend = (w_drv_cnt >= 3'd2);
    // hlt overrides every other bit; contention suppresses all updates.
    assign w_exec    = w_run && !w_hlt && !w_contend;

    // State sequencing and register/flag updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_pc      <= 4'h0;
            r_mar     <= 4'h0;
            r_ir      <= 8'h00;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_cf      <= 1'b0;
            r_zf      <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hlt) begin
                        r_state <= ST_HALT;
                    end else if (w_contend) begin
                        r_bus_err <= 1'b1;
                        r_state   <= ST_HALT;
                    end else begin
                        if (w_pc_inc)   r_pc  <= r_pc + 4'd1;
                        if (w_mar_load) r_mar <= w_bus[3:0];
                        if (w_ir_load)  r_ir  <= w_bus;
                        if (w_a_load)   r_a   <= w_bus;
                        if (w_b_load)   r_b   <= w_bus;
                        // Flags only track an ALU result written back into A.
                        if (w_a_load && w_adder_en) begin
                            r_cf <= w_sum9[8];
                            r_zf <= (w_sum9[7:0] == 8'h00);
                        end
                    end
                end
                ST_LOAD, ST_HALT: begin
                    if (dp.start) begin
                        r_state   <= ST_RUN;
                        r_pc      <= 4'h0;
                        r_mar     <= 4'h0;
                        r_ir      <= 8'h00;
                        r_a       <= 8'h00;
                        r_b       <= 8'h00;
                        r_cf      <= 1'b0;
                        r_zf      <= 1'b0;
                        r_bus_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Program RAM: bus stores while running, host writes otherwise; never reset
    always_ff @(posedge clk) begin
        if (w_exec && w_mem_st) begin
            r_ram[r_mar] <= w_bus;
        end else if (!w_run && dp.prog_we) begin
            r_ram[dp.prog_addr] <= dp.prog_data;
        end
    end

    // Controller stage reset, moved on the falling edge so the controller sees a stable level
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_rst <= 1'b1;
        end else begin
            r_ctrl_rst <= (r_state != ST_RUN);
        end
    end

    assign dp.opcode     = r_ir[7:4];
    assign dp.ctrl_rst   = r_ctrl_rst;
    assign dp.prog_rdata = r_ram[dp.prog_addr];
    assign dp.a_out      = r_a;
    assign dp.pc_out     = r_pc;
    assign dp.bus_out    = w_bus;
    assign dp.cf         = r_cf;
    assign dp.zf         = r_zf;
    assign dp.running    = (r_state == ST_RUN);
    assign dp.halted     = (r_state == ST_HALT);
    assign dp.bus_err    = r_bus_err;

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register/bus datapath for the 8-bit SAP-style CPU. It executes the 13-bit control word produced by the microcode controller and returns the current opcode to it. Internally it holds PC, MAR, a 16x8 RAM, IR, accumulator A, operand B, the adder/subtractor and the shared 8-bit bus. It also owns program loading, run/halt sequencing, and the controller's stage reset.

## Interface
Parameters:
- none; widths fixed: 8-bit data, 4-bit address, 16-word RAM

Ports:
- clk  in  1  system clock; all datapath state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ctrl  in  13  control word, MSB first: hlt, pc_inc, pc_en, mar_load, mem_st, mem_en, ir_load, ir_en, a_load, a_en, b_load, adder_sub, adder_en
- opcode  out  4  IR[7:4], combinational, to controller
- ctrl_rst  out  1  stage reset to controller; register updated on falling clk edge
- start  in  1  begin execution, sampled in LOAD/HALT
- prog_we  in  1  program write strobe
- prog_addr  in  4  program/readback address
- prog_data  in  8  program write data
- prog_rdata  out  8  RAM[prog_addr], combinational
- a_out  out  8  accumulator A
- pc_out  out  4  program counter
- bus_out  out  8  current bus value (debug)
- cf  out  1  carry / no-borrow flag
- zf  out  1  zero flag
- running  out  1  state == RUN
- halted  out  1  state == HALT
- bus_err  out  1  sticky bus-contention error

## Operation
- States: LOAD, RUN, HALT. State, PC, MAR, IR, A, B, cf, zf and bus_err are updated on the rising clk edge.
- Bus drivers: pc_en drives {4'h0, PC}; mem_en drives RAM[MAR]; ir_en drives {4'h0, IR[3:0]}; a_en drives A; adder_en drives the adder result. With no driver the bus is 8'h00.
- Contention: two or more drivers asserted in RUN.
  - bus_err is set to 1 and state goes to HALT.
  - No other register or RAM updates that cycle.
  - bus_out shows the OR of all drivers.
- Adder:
  - adder_sub=0: result = A+B mod 256, carry = bit 8 of the sum.
  - adder_sub=1: result = A-B mod 256, carry = (A >= B).
  - adder_sub without adder_en has no effect.
- Register updates in RUN, absent contention and hlt:
  - pc_inc: PC <= PC+1 mod 16 (15 wraps to 0).
  - mar_load: MAR <= bus[3:0].
  - mem_st: RAM[MAR] <= bus.
  - ir_load: IR <= bus.
  - a_load: A <= bus.
  - b_load: B <= bus.
  - a_load together with adder_en: cf <= carry and zf <= (result == 0). Otherwise flags hold.
  - Several loads in one cycle all take effect; all sample the same bus value.
- hlt in RUN: state goes to HALT. All other control bits in that cycle are ignored.
- LOAD/HALT:
  - ctrl is ignored.
  - prog_we writes RAM[prog_addr] <= prog_data. prog_we is ignored in RUN.
  - start goes to RUN and clears PC, MAR, IR, A, B, cf, zf and bus_err. RAM is retained.
  - start together with prog_we: the write happens and the state still goes to RUN.
- ctrl_rst <= (state != RUN) on each falling edge. Asserted in LOAD and HALT, holding the controller at stage 0.
- Reset: state LOAD, all registers and flags 0, bus_err 0, ctrl_rst 1. RAM is not cleared.
- Reset mid-RUN returns immediately to LOAD; RAM contents are kept.

## Timing
- start sampled at rising edge E0; running=1 after E0.
- ctrl_rst falls at the following falling edge. The controller still sees it high on that edge, so stage 0 is first executed at E1.
- Stage s of instruction k is captured at rising edge E(6(k-1)+s+1).
- hlt sampled at rising edge Eh: halted=1 and running=0 after Eh; ctrl_rst rises at the next falling edge.
- RAM write and register loads are visible the cycle after the capturing edge.
- prog_rdata and opcode have zero-cycle latency.

## Test plan
- Reset values: assert rst mid-RUN -> state LOAD, a_out=0, pc_out=0, cf=zf=bus_err=0, ctrl_rst=1. After release, the previously loaded program is still readable via prog_rdata.
- Full program:
  - Program: RAM[0..4] = 0x09, 0x1A, 0x2B, 0x3C, 0xF0; RAM[9]=0x05, RAM[10]=0x03, RAM[11]=0x0A.
  - Stimulus: start, paired with the controller.
  - Required: halted rises 28 rising edges after start; a_out=0xFE, cf=0, zf=0, pc_out=5; RAM[12] reads 0xFE.
- Zero flag: A=0x07, B=0x07, SUB -> a_out=0x00, zf=1, cf=1. ADD 0xFF+0x01 -> a_out=0x00, cf=1, zf=1.
- PC wrap: pc_inc with PC=15 -> PC=0.
- Contention: drive ctrl with pc_en and a_en together in RUN -> bus_err=1, halted=1; A, PC and RAM unchanged. A subsequent start clears bus_err.
- Load gating: prog_we during RUN -> RAM unchanged. prog_we with start in HALT -> write lands and running=1 next cycle.
